seg_mux_ctrl: RTL and testbench
===============================

// Module: seg_mux_ctrl
// PURPOSE
// - Time-multiplexes two hex digits onto one shared seg_display decoder and a dual common-anode 7-segment display.
// - Alternates digit 0 and digit 1 at a fixed refresh rate and drives the active-low anode enables.
// - Samples both nibbles once per frame so a digit never changes mid-window (no tearing).
// - Sits between the switch/logic inputs and the display pins; the decoder is instantiated internally.
// PARAMETERS
// - REFRESH_DIV  default 24000  clk cycles each digit stays lit; 48 MHz -> 1 kHz/digit; must be >= 2
// - BLANK_CYC    default 16     all-off cycles between digit windows; must be >= 1; used only with SEG_BLANK_EN
// PORTS
// - clk    in   1  system clock, all state on rising edge
// - reset  in   1  asynchronous, active-high reset
// - s0     in   4  hex value for digit 0
// - s1     in   4  hex value for digit 1
// - hex_sel out 4  nibble currently driven into the shared decoder (registered)
// - seg    out  7  segment pattern = seg_display(hex_sel); combinational from hex_sel only
// - an_n   out  2  anode enables, active-low; [0] = digit 0, [1] = digit 1 (registered)
// - frame  out  1  one-cycle pulse on the first cycle of each digit-0 window (registered)
// BEHAVIOUR
// - Reset is asserted asynchronously: state=SHOW0, counter=0, latched nibbles=0; an_n=2'b11, hex_sel=4'h0, frame=0.
// - States: SHOW0 -> [BLANK01] -> SHOW1 -> [BLANK10] -> SHOW0; BLANK states exist only with SEG_BLANK_EN.
// - One counter, width $clog2(max(REFRESH_DIV,BLANK_CYC)):
//   - Clears on every state change.
//   - Advances the state when it reaches REFRESH_DIV-1 in a SHOW state, or BLANK_CYC-1 in a BLANK state.
// - First rising edge after reset deasserts starts the first digit-0 window:
//   - an_n=2'b10, hex_sel=s0 as sampled on that edge, frame=1.
// - Outputs per window, all held for the whole window:
//   - SHOW0: an_n=2'b10, hex_sel=latched s0.
//   - SHOW1: an_n=2'b01, hex_sel=latched s1.
//   - BLANK: an_n=2'b11, hex_sel holds its previous value.
// - Input sampling:
//   - s0 and s1 are both captured on the edge that starts each digit-0 window, and only then.
//   - Changes at any other time are displayed from the next frame onward.
// - frame goes high only for the first cycle of each digit-0 window; it is 0 in all other cycles.
// - Never more than one anode low in any cycle, including at state transitions and during reset.
// - Reset mid-frame, in any state: an_n goes to 2'b11 immediately, without waiting for clk; the sequence restarts at a fresh digit-0 window.
// - Frame period:
//   - 2*REFRESH_DIV cycles without SEG_BLANK_EN.
//   - 2*(REFRESH_DIV+BLANK_CYC) cycles with it.
// CONFIGURATION
// - SEG_BLANK_EN defined:
//   - BLANK01 and BLANK10 states are present.
//   - BLANK_CYC all-off cycles are inserted between digit windows to suppress ghosting on the transistor drivers.
// - SEG_BLANK_EN undefined:
//   - Direct SHOW0 <-> SHOW1 alternation; BLANK_CYC is ignored.
//   - an_n switches 2'b10 <-> 2'b01 in a single edge.
// TESTING (bench parameters: REFRESH_DIV=4, BLANK_CYC=2, 10 ns clk)
// - Reset hold: reset=1 for 3 cycles, s0=4'h5 -> an_n=2'b11, hex_sel=0, frame=0 throughout; an_n=2'b11 also before the first clk edge.
// - No blanking, s0=4'h3, s1=4'hA, reset released:
//   - Repeating pattern {an_n=10, hex_sel=3} x4 cycles, then {an_n=01, hex_sel=A} x4 cycles.
//   - frame=1 every 8th cycle, aligned with the first an_n=10 cycle.
// - SEG_BLANK_EN, same inputs:
//   - Pattern: 4x{10,3}, 2x{11}, 4x{01,A}, 2x{11}; period 12.
//   - Bench flags any cycle with an_n=2'b00.
// - Tearing check, during the second cycle of a digit-1 window:
//   - Change s1 A->7 -> hex_sel stays A for the rest of that window and shows 7 in the next frame's digit-1 window.
//   - Change s0 3->E mid digit-0 window -> 3 remains until the next frame.
// - Async reset: assert reset between edges in the 3rd cycle of SHOW1:
//   - an_n=2'b11 before the next edge.
//   - After release: full 4-cycle digit-0 window with frame=1 first.
// - Sweep: step s0 and s1 through all 16 values, one value per frame:
//   - seg matches the seg_display golden vector for hex_sel in every lit cycle.
//   - Report the error count at the end.

Source files
------------

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: drives two hex digits through one shared 7-segment decoder onto a dual common-anode display.
// Define SEG_BLANK_EN to insert BLANK_CYC all-off cycles between digit windows.

module seg_display (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Segments are active-low, ordered {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// state   | meaning
// SHOW0   | digit 0 lit, an_n=10
// BLANK01 | all off between digit 0 and digit 1
// SHOW1   | digit 1 lit, an_n=01
// BLANK10 | all off between digit 1 and the next frame
module seg_mux_ctrl #(
  parameter int REFRESH_DIV = 24000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] hex_sel,
  output logic [6:0] seg,
  output logic [1:0] an_n,
  output logic       frame
);
  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
`ifdef SEG_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  typedef enum logic [1:0] {SHOW0, BLANK01, SHOW1, BLANK10} state_t;
`else
  typedef enum logic [1:0] {SHOW0, SHOW1} state_t;
`endif

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic started, enter;
  logic [3:0] lat1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    enter     = 1'b0;
    if (!started) begin
      // first edge out of reset opens a fresh digit-0 window
      state_nxt = SHOW0;
      enter     = 1'b1;
    end else begin
      case (state)
        SHOW0: if (cnt == SHOW_LAST) begin
`ifdef SEG_BLANK_EN
          state_nxt = BLANK01;
`else
          state_nxt = SHOW1;
`endif
          enter = 1'b1;
        end
        SHOW1: if (cnt == SHOW_LAST) begin
`ifdef SEG_BLANK_EN
          state_nxt = BLANK10;
`else
          state_nxt = SHOW0;
`endif
          enter = 1'b1;
        end
`ifdef SEG_BLANK_EN
        BLANK01: if (cnt == BLANK_LAST) begin
          state_nxt = SHOW1;
          enter     = 1'b1;
        end
        BLANK10: if (cnt == BLANK_LAST) begin
          state_nxt = SHOW0;
          enter     = 1'b1;
        end
`endif
        default: begin
          state_nxt = SHOW0;
          enter     = 1'b1;
        end
      endcase
    end
    if (enter) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SHOW0;
      cnt     <= '0;
      started <= 1'b0;
      lat1    <= 4'h0;
      an_n    <= 2'b11;
      hex_sel <= 4'h0;
      frame   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      started <= 1'b1;
      frame   <= enter && (state_nxt == SHOW0);
      // outputs only change on window boundaries, so a window never tears
      if (enter) begin
        case (state_nxt)
          SHOW0: begin
            lat1    <= s1;
            hex_sel <= s0;
            an_n    <= 2'b10;
          end
          SHOW1: begin
            hex_sel <= lat1;
            an_n    <= 2'b01;
          end
          default: an_n <= 2'b11;
        endcase
      end
    end
  end

  seg_display u_dec (
    .hex (hex_sel),
    .seg (seg)
  );
endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Bench for seg_mux_ctrl: per-cycle comparison against a frame-phase model plus pinned literal checks.
// Honours SEG_BLANK_EN to match the build under test.
module tb_seg_mux_ctrl;
  localparam int R = 4;
  localparam int B = 2;
`ifdef SEG_BLANK_EN
  localparam int BE = B;
`else
  localparam int BE = 0;
`endif
  localparam int P = 2 * (R + BE);

  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] s0, s1;
  logic [3:0] hex_sel;
  logic [6:0] seg;
  logic [1:0] an_n;
  logic       frame;

  seg_mux_ctrl #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk     (clk),
    .reset   (rst),
    .s0      (s0),
    .s1      (s1),
    .hex_sel (hex_sel),
    .seg     (seg),
    .an_n    (an_n),
    .frame   (frame)
  );

  int vectors = 0;
  int errors  = 0;
  int k = -1;
  logic [3:0] m0 = 4'h0, m1 = 4'h0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // k counts cycles since the first window opened; frame contents are captured at each frame start
  always @(posedge clk) begin
    if (rst) k = -1;
    else begin
      k = k + 1;
      if (k % P == 0) begin
        m0 = s0;
        m1 = s1;
      end
    end
  end

  function automatic logic [1:0] exp_an(input int kk);
    int ph;
    if (kk < 0) return 2'b11;
    ph = kk % P;
    if (ph < R) return 2'b10;
    if (ph < R + BE) return 2'b11;
    if (ph < 2 * R + BE) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [3:0] exp_hex(input int kk);
    if (kk < 0) return 4'h0;
    return ((kk % P) < R + BE) ? m0 : m1;
  endfunction

  function automatic logic [6:0] golden(input logic [3:0] h);
    logic [6:0] on;
    on = SEG_ON[h];
    return ~on;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int kk;
      kk = rst ? -1 : k;
      chk("an_n", {30'd0, an_n}, {30'd0, exp_an(kk)});
      chk("hex_sel", {28'd0, hex_sel}, {28'd0, exp_hex(kk)});
      chk("frame", {31'd0, frame}, {31'd0, (kk >= 0 && kk % P == 0)});
      chk("seg", {25'd0, seg}, {25'd0, golden(exp_hex(kk))});
      chk("one_anode", {31'd0, an_n == 2'b00}, 32'd0);
    end
  end

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(k >= 0 && k % P == ph) && n < 200);
    if (n >= 200) begin
      vectors++;
      errors++;
      $display("FAIL wait_phase %0d: timed out, got no match, expected phase %0d", ph, ph);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s0 = 4'h5; s1 = 4'h0; rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("an_pre_edge", {30'd0, an_n}, 32'h3);
    chk("hex_pre_edge", {28'd0, hex_sel}, 32'h0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 s0 = 4'h3; s1 = 4'hA;
    @(posedge clk);
    #2 rst = 1'b0;

    wait_phase(0);
    chk("lit_first_an", {30'd0, an_n}, 32'h2);
    chk("lit_first_hex", {28'd0, hex_sel}, 32'h3);
    chk("lit_first_frame", {31'd0, frame}, 32'h1);
    wait_phase(R);
`ifdef SEG_BLANK_EN
    chk("lit_blank01_an", {30'd0, an_n}, 32'h3);
    chk("lit_blank01_hex", {28'd0, hex_sel}, 32'h3);
`else
    chk("lit_show1_an", {30'd0, an_n}, 32'h1);
    chk("lit_show1_hex", {28'd0, hex_sel}, 32'hA);
`endif
    wait_phase(R + BE);
    chk("lit_d1_an", {30'd0, an_n}, 32'h1);
    chk("lit_d1_frame", {31'd0, frame}, 32'h0);

    wait_phase(R + BE + 1);
    #1 s1 = 4'h7;
    wait_phase(R + BE + 3);
    chk("lit_tear_s1_hold", {28'd0, hex_sel}, 32'hA);
    wait_phase(1);
    #1 s0 = 4'hE;
    wait_phase(2);
    chk("lit_tear_s0_hold", {28'd0, hex_sel}, 32'h3);
    wait_phase(R + BE);
    chk("lit_s1_new", {28'd0, hex_sel}, 32'h7);
    wait_phase(0);
    chk("lit_s0_new", {28'd0, hex_sel}, 32'hE);
    chk("lit_s0_new_frame", {31'd0, frame}, 32'h1);

    wait_phase(R + BE + 2);
    #1 rst = 1'b1;
    #1;
    chk("lit_async_an", {30'd0, an_n}, 32'h3);
    chk("lit_async_frame", {31'd0, frame}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_phase(0);
    chk("lit_restart_an", {30'd0, an_n}, 32'h2);
    chk("lit_restart_frame", {31'd0, frame}, 32'h1);
    chk("lit_restart_hex", {28'd0, hex_sel}, 32'hE);

    for (int v = 0; v < 16; v++) begin
      wait_phase(1);
      #1 s0 = 4'(v); s1 = 4'(15 - v);
      wait_phase(0);
      chk("sweep_s0", {28'd0, hex_sel}, v);
      wait_phase(R + BE);
      chk("sweep_s1", {28'd0, hex_sel}, 15 - v);
    end
    wait_phase(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
